// File: rtl/gba_rom_responder.sv
// Cartridge-side slot-2 ROM bus responder: oversamples the async console bus,
// prefetches halfwords from a backing memory, drives reads and reports writes.
module gba_rom_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ncs,
  input  logic        nrd,
  input  logic        nwr,
  input  logic [7:0]  a_hi,
  input  logic [15:0] ad_in,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  output logic [23:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        wr_valid,
  output logic [23:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        late_rd
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int SW = 27;

  typedef enum logic [2:0] {IDLE, FETCH, READY, DRIVE, FLUSH} state_t;

  // All pins share one shift chain so data stays time-aligned with the strobes.
  logic [NS*SW-1:0] sync_reg;
  logic [SW-1:0]    sync_top;
  logic             ncs_s, nrd_s, nwr_s;
  logic [7:0]       a_hi_s;
  logic [15:0]      ad_s;
  logic             ncs_p, nrd_p, nwr_p;
  logic             cs_fall, cs_rise, rd_fall, rd_rise, wr_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '1;
      ncs_p    <= 1'b1;
      nrd_p    <= 1'b1;
      nwr_p    <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[(NS-1)*SW-1:0], ncs, nrd, nwr, a_hi, ad_in};
      ncs_p    <= ncs_s;
      nrd_p    <= nrd_s;
      nwr_p    <= nwr_s;
    end
  end

  assign sync_top = sync_reg[NS*SW-1 -: SW];
  assign ncs_s    = sync_top[26];
  assign nrd_s    = sync_top[25];
  assign nwr_s    = sync_top[24];
  assign a_hi_s   = sync_top[23:16];
  assign ad_s     = sync_top[15:0];

  assign cs_fall = ncs_p & ~ncs_s;
  assign cs_rise = ~ncs_p & ncs_s;
  assign rd_fall = nrd_p & ~nrd_s;
  assign rd_rise = ~nrd_p & nrd_s;
  assign wr_rise = ~nwr_p & nwr_s;

  function automatic logic [23:0] addr_inc(input logic [23:0] a);
    return {a[23:16], a[15:0] + 16'd1};
  endfunction

  state_t      state_reg, state_next;
  logic [23:0] addr_reg, addr_next;
  logic [15:0] buf_reg, buf_next;
  logic        mem_req_reg, mem_req_next;
  logic [23:0] mem_addr_reg, mem_addr_next;
  logic        ad_oe_reg, ad_oe_next;
  logic [15:0] ad_out_reg, ad_out_next;
  logic        wr_valid_reg, wr_valid_next;
  logic [23:0] wr_addr_reg, wr_addr_next;
  logic [15:0] wr_data_reg, wr_data_next;
  logic        late_rd_reg, late_rd_next;
  logic        rd_late_reg, rd_late_next;   // driving 16'hFFFF while waiting for data
  logic        discard_reg, discard_next;   // outstanding fetch is stale, drop its data
  logic        pend_reg, pend_next;         // new session latched during FLUSH
  logic        ack, wr_hit;

  assign ack    = mem_ack & mem_req_reg;
  assign wr_hit = wr_rise & ~ncs_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      buf_reg      <= '0;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
      ad_oe_reg    <= 1'b0;
      ad_out_reg   <= 16'hFFFF;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      late_rd_reg  <= 1'b0;
      rd_late_reg  <= 1'b0;
      discard_reg  <= 1'b0;
      pend_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      buf_reg      <= buf_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
      ad_oe_reg    <= ad_oe_next;
      ad_out_reg   <= ad_out_next;
      wr_valid_reg <= wr_valid_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      late_rd_reg  <= late_rd_next;
      rd_late_reg  <= rd_late_next;
      discard_reg  <= discard_next;
      pend_reg     <= pend_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    buf_next      = buf_reg;
    mem_req_next  = mem_req_reg & ~ack;
    mem_addr_next = mem_addr_reg;
    ad_oe_next    = ad_oe_reg;
    ad_out_next   = ad_out_reg;
    wr_valid_next = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    late_rd_next  = late_rd_reg;
    rd_late_next  = rd_late_reg;
    discard_next  = discard_reg;
    pend_next     = pend_reg;

    if (wr_hit) begin
      wr_valid_next = 1'b1;
      wr_addr_next  = addr_reg;
      wr_data_next  = ad_s;
      addr_next     = addr_inc(addr_reg);
    end

    if (cs_rise) begin
      // Session end beats a simultaneous rd_rise: no increment, no prefetch.
      ad_oe_next   = 1'b0;
      rd_late_next = 1'b0;
      discard_next = 1'b0;
      pend_next    = 1'b0;
      state_next   = (mem_req_reg && !ack) ? FLUSH : IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            addr_next     = {a_hi_s, ad_s};
            mem_req_next  = 1'b1;
            mem_addr_next = {a_hi_s, ad_s};
            state_next    = FETCH;
          end
        end
        FETCH: begin
          if (wr_hit || (rd_rise && rd_late_reg)) begin
            // Fetch in flight now targets the wrong address; refetch at the new one.
            if (!wr_hit) addr_next = addr_inc(addr_reg);
            ad_oe_next   = 1'b0;
            rd_late_next = 1'b0;
            if (ack) begin
              mem_req_next  = 1'b1;
              mem_addr_next = addr_next;
              discard_next  = 1'b0;
            end else begin
              discard_next = 1'b1;
            end
          end else if (ack && discard_reg) begin
            mem_req_next  = 1'b1;
            mem_addr_next = addr_reg;
            discard_next  = 1'b0;
            if (rd_fall) begin
              ad_oe_next   = 1'b1;
              ad_out_next  = 16'hFFFF;
              late_rd_next = 1'b1;
              rd_late_next = 1'b1;
            end
          end else if (ack) begin
            buf_next = mem_rdata;
            if (rd_fall || rd_late_reg) begin
              ad_oe_next   = 1'b1;
              ad_out_next  = mem_rdata;
              rd_late_next = 1'b0;
              state_next   = DRIVE;
            end else begin
              state_next = READY;
            end
          end else if (rd_fall) begin
            ad_oe_next   = 1'b1;
            ad_out_next  = 16'hFFFF;
            late_rd_next = 1'b1;
            rd_late_next = 1'b1;
          end
        end
        READY: begin
          if (wr_hit) begin
            mem_req_next  = 1'b1;
            mem_addr_next = addr_next;
            state_next    = FETCH;
          end else if (rd_fall) begin
            ad_oe_next  = 1'b1;
            ad_out_next = buf_reg;
            state_next  = DRIVE;
          end
        end
        DRIVE: begin
          if (wr_hit || rd_rise) begin
            if (!wr_hit) addr_next = addr_inc(addr_reg);
            ad_oe_next    = 1'b0;
            mem_req_next  = 1'b1;
            mem_addr_next = addr_next;
            state_next    = FETCH;
          end
        end
        FLUSH: begin
          if (cs_fall) begin
            addr_next = {a_hi_s, ad_s};
            pend_next = 1'b1;
          end
          if (ack) begin
            if (cs_fall || pend_reg) begin
              mem_req_next  = 1'b1;
              mem_addr_next = addr_next;
              pend_next     = 1'b0;
              state_next    = FETCH;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign ad_out   = ad_out_reg;
  assign ad_oe    = ad_oe_reg;
  assign mem_addr = mem_addr_reg;
  assign mem_req  = mem_req_reg;
  assign wr_valid = wr_valid_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign late_rd  = late_rd_reg;

endmodule
